// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer: FSM states,
// opcodes, flag bit positions and the program word layout.
package alu_op_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_KICK    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_HOLD    = 3'd5,
      ST_FINISH  = 3'd6
   } seq_state_e;

   localparam int INSTR_W       = 22;
   localparam int SEL_W         = 5;
   localparam int OPND_W        = 8;
   localparam int FLAG_W        = 6;
   localparam int USE_CARRY_BIT = 21;
   localparam int SEL_LSB       = 16;
   localparam int OPA_LSB       = 8;
   localparam int OPB_LSB       = 0;

   localparam logic [SEL_W-1:0] OP_ADD    = 5'b00000;
   localparam logic [SEL_W-1:0] OP_ADDC   = 5'b00001;
   localparam logic [SEL_W-1:0] OP_SUB    = 5'b00010;
   localparam logic [SEL_W-1:0] OP_SUBB   = 5'b00011;
   localparam logic [SEL_W-1:0] OP_DIV    = 5'b00100;
   localparam logic [SEL_W-1:0] OP_MOD    = 5'b00101;
   localparam logic [SEL_W-1:0] OP_AND    = 5'b00110;
   localparam logic [SEL_W-1:0] OP_OR     = 5'b00111;
   localparam logic [SEL_W-1:0] OP_XOR    = 5'b01000;
   localparam logic [SEL_W-1:0] OP_NOT    = 5'b01001;
   localparam logic [SEL_W-1:0] OP_SHL    = 5'b01010;
   localparam logic [SEL_W-1:0] OP_SHR    = 5'b01011;
   localparam logic [SEL_W-1:0] OP_ASR    = 5'b01100;
   localparam logic [SEL_W-1:0] OP_ROL    = 5'b01101;
   localparam logic [SEL_W-1:0] OP_ROR    = 5'b01110;
   localparam logic [SEL_W-1:0] OP_INC    = 5'b01111;
   localparam logic [SEL_W-1:0] OP_DEC    = 5'b10000;
   localparam logic [SEL_W-1:0] OP_NEG    = 5'b10001;
   localparam logic [SEL_W-1:0] OP_CMP    = 5'b10010;
   localparam logic [SEL_W-1:0] OP_MULLO  = 5'b10011;
   localparam logic [SEL_W-1:0] OP_MULHI  = 5'b10100;
   localparam logic [SEL_W-1:0] OP_PASS1  = 5'b10101;
   localparam logic [SEL_W-1:0] OP_PASS2  = 5'b10110;
   localparam logic [SEL_W-1:0] OP_NOP    = 5'b11111;

   localparam int FLAG_ZERO   = 5;
   localparam int FLAG_SIGN   = 4;
   localparam int FLAG_PARITY = 3;
   localparam int FLAG_OVF    = 2;
   localparam int FLAG_CARRY  = 1;
   localparam int FLAG_AUX    = 0;

   typedef struct packed {
      logic              use_carry;
      logic [SEL_W-1:0]  sel;
      logic [OPND_W-1:0] op_a;
      logic [OPND_W-1:0] op_b;
   } instr_t;

   // Division or modulo by zero is diverted to the ALU default opcode.
   function automatic logic is_div0(instr_t instr);
      return ((instr.sel == OP_DIV) || (instr.sel == OP_MOD)) && (instr.op_b == 8'd0);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_prog_mem.sv
// Program store for the sequencer: synchronous write, asynchronous read,
// contents survive reset.
module alu_prog_mem
   import alu_op_sequencer_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               in_clk,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [INSTR_W-1:0] rd_data
);

   logic [INSTR_W-1:0] mem_r [DEPTH];

   // Write port.
   always_ff @(posedge in_clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps through a stored ALU program: drives operands, waits for the ALU to
// settle, hands each result out over a valid/ready port and kicks the ALU watchdog.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int SETTLE_CYCLES = 1,
   parameter int KICK_EVERY    = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               in_clk,
   input  logic               in_rst,
   input  logic               prog_wr_en,
   input  logic [AW-1:0]      prog_wr_addr,
   input  logic [21:0]        prog_wr_data,
   input  logic [AW:0]        prog_len,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [4:0]         alu_sel,
   output logic signed [7:0]  alu_in_1,
   output logic signed [7:0]  alu_in_2,
   output logic               alu_carry,
   output logic               alu_wdt_rst,
   input  logic signed [7:0]  alu_out,
   input  logic [5:0]         alu_flags,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [7:0]         res_data,
   output logic [5:0]         res_flags,
   output logic [AW-1:0]      res_index,
   output logic               res_div0
);

   localparam int KW = $clog2(KICK_EVERY + 1);
   localparam logic [KW-1:0] KICK_LAST   = KW'(KICK_EVERY);
   localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_LEN   = (AW+1)'(DEPTH);

   seq_state_e       state_r;
   logic [AW-1:0]    index_r;
   logic [AW:0]      len_r;
   logic [KW-1:0]    issue_cnt_r;
   logic [3:0]       settle_cnt_r;
   logic             carry_chain_r;
   logic             div0_r;

   logic             busy_r;
   logic             done_r;
   logic [4:0]       alu_sel_r;
   logic [7:0]       alu_in_1_r;
   logic [7:0]       alu_in_2_r;
   logic             alu_carry_r;
   logic             alu_wdt_rst_r;
   logic             res_valid_r;
   logic [7:0]       res_data_r;
   logic [5:0]       res_flags_r;
   logic [AW-1:0]    res_index_r;
   logic             res_div0_r;

   logic [INSTR_W-1:0] rd_data_s;
   logic [AW-1:0]      rd_addr_s;
   instr_t             cur_instr_s;
   logic               wr_en_s;
   logic [AW:0]        len_clamped_s;
   logic               last_s;
   logic               handshake_s;
   logic               issue_div0_s;
   logic [4:0]         issue_sel_s;
   logic               issue_carry_s;

   alu_prog_mem #(
      .DEPTH (DEPTH)
   ) u_prog_mem (
      .in_clk  (in_clk),
      .wr_en   (wr_en_s),
      .wr_addr (prog_wr_addr),
      .wr_data (prog_wr_data),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Decode of the entry about to be issued and the handshake/length conditions.
   always_comb begin
      wr_en_s     = prog_wr_en & ~busy_r;
      handshake_s = res_valid_r & res_ready;
      // From HOLD the next issue happens on the same edge that advances index_r.
      if (state_r == ST_HOLD) begin
         rd_addr_s = index_r + AW'(1'b1);
      end else begin
         rd_addr_s = index_r;
      end
      cur_instr_s  = instr_t'(rd_data_s);
      issue_div0_s = is_div0(cur_instr_s);
      if (issue_div0_s) begin
         issue_sel_s = OP_NOP;
      end else begin
         issue_sel_s = cur_instr_s.sel;
      end
      if (cur_instr_s.use_carry) begin
         issue_carry_s = carry_chain_r;
      end else begin
         issue_carry_s = 1'b0;
      end
      if (prog_len > DEPTH_LEN) begin
         len_clamped_s = DEPTH_LEN;
      end else begin
         len_clamped_s = prog_len;
      end
      last_s = ({1'b0, index_r} == (len_r - (AW+1)'(1'b1)));
   end

   // Sequencer FSM with all ALU-side and result-side outputs registered.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_r       <= ST_IDLE;
         index_r       <= {AW{1'b0}};
         len_r         <= {(AW+1){1'b0}};
         issue_cnt_r   <= {KW{1'b0}};
         settle_cnt_r  <= 4'd0;
         carry_chain_r <= 1'b0;
         div0_r        <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         alu_sel_r     <= 5'd0;
         alu_in_1_r    <= 8'd0;
         alu_in_2_r    <= 8'd0;
         alu_carry_r   <= 1'b0;
         alu_wdt_rst_r <= 1'b1;
         res_valid_r   <= 1'b0;
         res_data_r    <= 8'd0;
         res_flags_r   <= 6'd0;
         res_index_r   <= {AW{1'b0}};
         res_div0_r    <= 1'b0;
      end else begin
         done_r        <= 1'b0;
         alu_wdt_rst_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  carry_chain_r <= 1'b0;
                  index_r       <= {AW{1'b0}};
                  len_r         <= len_clamped_s;
                  if (prog_len == {(AW+1){1'b0}}) begin
                     state_r <= ST_FINISH;
                     done_r  <= 1'b1;
                  end else begin
                     state_r       <= ST_KICK;
                     busy_r        <= 1'b1;
                     alu_wdt_rst_r <= 1'b1;
                     issue_cnt_r   <= {KW{1'b0}};
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_KICK: begin
               state_r     <= ST_ISSUE;
               alu_sel_r   <= issue_sel_s;
               alu_in_1_r  <= cur_instr_s.op_a;
               alu_in_2_r  <= cur_instr_s.op_b;
               alu_carry_r <= issue_carry_s;
               div0_r      <= issue_div0_s;
               issue_cnt_r <= issue_cnt_r + KW'(1'b1);
            end
            ST_ISSUE: begin
               state_r      <= ST_SETTLE;
               settle_cnt_r <= SETTLE_INIT;
            end
            ST_SETTLE: begin
               if (settle_cnt_r == 4'd0) begin
                  state_r <= ST_CAPTURE;
               end else begin
                  settle_cnt_r <= settle_cnt_r - 4'd1;
               end
            end
            ST_CAPTURE: begin
               state_r       <= ST_HOLD;
               res_valid_r   <= 1'b1;
               res_data_r    <= div0_r ? 8'd0 : alu_out;
               res_flags_r   <= alu_flags;
               res_index_r   <= index_r;
               res_div0_r    <= div0_r;
               carry_chain_r <= alu_flags[FLAG_CARRY];
            end
            ST_HOLD: begin
               if (handshake_s) begin
                  res_valid_r <= 1'b0;
                  if (last_s) begin
                     state_r <= ST_FINISH;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     index_r <= index_r + AW'(1'b1);
                     if (issue_cnt_r == KICK_LAST) begin
                        state_r       <= ST_KICK;
                        alu_wdt_rst_r <= 1'b1;
                        issue_cnt_r   <= {KW{1'b0}};
                     end else begin
                        state_r     <= ST_ISSUE;
                        alu_sel_r   <= issue_sel_s;
                        alu_in_1_r  <= cur_instr_s.op_a;
                        alu_in_2_r  <= cur_instr_s.op_b;
                        alu_carry_r <= issue_carry_s;
                        div0_r      <= issue_div0_s;
                        issue_cnt_r <= issue_cnt_r + KW'(1'b1);
                     end
                  end
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            ST_FINISH: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign alu_sel     = alu_sel_r;
   assign alu_in_1    = alu_in_1_r;
   assign alu_in_2    = alu_in_2_r;
   assign alu_carry   = alu_carry_r;
   assign alu_wdt_rst = alu_wdt_rst_r;
   assign res_valid   = res_valid_r;
   assign res_data    = res_data_r;
   assign res_flags   = res_flags_r;
   assign res_index   = res_index_r;
   assign res_div0    = res_div0_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a behavioural ALU and a
// program-level reference model of the expected result stream.
module tb_alu_op_sequencer;

   localparam int DEPTH  = 16;
   localparam int SETTLE = 2;
   localparam int KE     = 8;
   localparam int AW     = 4;

   logic              in_clk = 1'b0;
   logic              in_rst;
   logic              prog_wr_en;
   logic [AW-1:0]     prog_wr_addr;
   logic [21:0]       prog_wr_data;
   logic [AW:0]       prog_len;
   logic              start;
   logic              busy, done;
   logic [4:0]        alu_sel;
   logic [7:0]        alu_in_1, alu_in_2;
   logic              alu_carry, alu_wdt_rst;
   logic [7:0]        alu_out;
   logic [5:0]        alu_flags;
   logic              res_valid, res_ready;
   logic [7:0]        res_data;
   logic [5:0]        res_flags;
   logic [AW-1:0]     res_index;
   logic              res_div0;

   int n_checks = 0;
   int n_errors = 0;

   logic [21:0] prog_m  [DEPTH];
   logic [7:0]  e_data  [DEPTH];
   logic [5:0]  e_flags [DEPTH];
   logic [4:0]  e_sel   [DEPTH];
   logic [7:0]  e_a     [DEPTH];
   logic [7:0]  e_b     [DEPTH];
   logic        e_cin   [DEPTH];
   logic        e_div0  [DEPTH];
   logic [7:0]  obs_data  [DEPTH];
   logic [5:0]  obs_flags [DEPTH];
   logic [4:0]  obs_sel   [DEPTH];
   logic        obs_carry [DEPTH];
   logic        obs_div0  [DEPTH];

   always #5 in_clk = ~in_clk;

   alu_op_sequencer #(
      .DEPTH (DEPTH), .SETTLE_CYCLES (SETTLE), .KICK_EVERY (KE)
   ) dut (
      .in_clk (in_clk), .in_rst (in_rst),
      .prog_wr_en (prog_wr_en), .prog_wr_addr (prog_wr_addr), .prog_wr_data (prog_wr_data),
      .prog_len (prog_len), .start (start), .busy (busy), .done (done),
      .alu_sel (alu_sel), .alu_in_1 (alu_in_1), .alu_in_2 (alu_in_2),
      .alu_carry (alu_carry), .alu_wdt_rst (alu_wdt_rst),
      .alu_out (alu_out), .alu_flags (alu_flags),
      .res_valid (res_valid), .res_ready (res_ready), .res_data (res_data),
      .res_flags (res_flags), .res_index (res_index), .res_div0 (res_div0)
   );

   // Behavioural ALU: returns {zero,sign,parity,overflow,carry,aux, result}.
   function automatic logic [13:0] alu_fn(logic [4:0] sel, logic [7:0] a, logic [7:0] b, logic cin);
      logic [8:0] w;
      logic [7:0] r;
      logic c, v, ac;
      w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0; ac = 1'b0;
      case (sel)
         5'd0, 5'd1: begin
            w  = {1'b0, a} + {1'b0, b} + ((sel == 5'd1) ? {8'd0, cin} : 9'd0);
            r  = w[7:0]; c = w[8];
            v  = (a[7] == b[7]) && (r[7] != a[7]);
            ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + ((sel == 5'd1) ? {4'd0, cin} : 5'd0)) > 5'd15;
         end
         5'd2: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[7:0]; c = w[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         5'd4:  r = (b != 8'd0) ? a / b : 8'd0;
         5'd5:  r = (b != 8'd0) ? a % b : 8'd0;
         5'd6:  r = a & b;
         5'd8:  r = a ^ b;
         5'd22: r = b;
         default: r = 8'd0;
      endcase
      return {(r == 8'd0), r[7], ~^r, v, c, ac, r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_fn(alu_sel, alu_in_1, alu_in_2, alu_carry);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_prog(input int addr, input logic [21:0] data);
      prog_wr_en = 1'b1; prog_wr_addr = AW'(addr); prog_wr_data = data;
      @(posedge in_clk); #1;
      prog_wr_en = 1'b0;
      prog_m[addr] = data;
   endtask

   task automatic rand_prog(input int n);
      int ops [8] = '{0, 1, 2, 4, 5, 6, 8, 22};
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         write_prog(i, {1'($urandom_range(0, 1)), 5'(ops[$urandom_range(0, 7)]),
                        8'($urandom_range(0, 255)), b});
      end
   endtask

   // Expected result stream computed from the program contents.
   task automatic build_model(input int n);
      logic chain = 1'b0;
      logic [4:0] sel;
      logic [13:0] fr;
      for (int i = 0; i < n; i++) begin
         sel       = prog_m[i][20:16];
         e_a[i]    = prog_m[i][15:8];
         e_b[i]    = prog_m[i][7:0];
         e_div0[i] = ((sel == 5'd4) || (sel == 5'd5)) && (e_b[i] == 8'd0);
         e_cin[i]  = prog_m[i][21] ? chain : 1'b0;
         e_sel[i]  = e_div0[i] ? 5'd31 : sel;
         fr        = alu_fn(e_sel[i], e_a[i], e_b[i], e_cin[i]);
         e_data[i] = e_div0[i] ? 8'd0 : fr[7:0];
         e_flags[i] = fr[13:8];
         chain     = fr[9];
      end
   endtask

   // mode 0: ready always, 1: random ready, 2: ready low 5 cycles per result.
   task automatic run_prog(input int len_in, input int mode, input int abort_at);
      int n, cyc, seen, stall, done_cyc, exp_kicks;
      bit got_done, prev_valid, prev_ready, hs, saw_done;
      logic [31:0] snap;
      int kick_q [$];
      n = (len_in > DEPTH) ? DEPTH : len_in;
      build_model(n);
      exp_kicks = (n == 0) ? 0 : ((n - 1) / KE + 1);
      prog_len = (AW+1)'(len_in); start = 1'b1; res_ready = (mode != 2);
      @(posedge in_clk); #1;
      start = 1'b0;
      cyc = 0; seen = 0; stall = 0; done_cyc = -1; got_done = 0; snap = 32'd0;
      prev_valid = 0; prev_ready = res_ready;
      while (!got_done && cyc < 4000) begin
         hs = prev_valid && prev_ready;
         if (alu_wdt_rst) kick_q.push_back(seen);
         if (res_valid && (!prev_valid || hs)) begin
            if (seen < n) begin
               check_val($sformatf("res_data[%0d]", seen), res_data, e_data[seen]);
               check_val($sformatf("res_flags[%0d]", seen), res_flags, e_flags[seen]);
               check_val($sformatf("res_index[%0d]", seen), res_index, seen);
               check_val($sformatf("res_div0[%0d]", seen), res_div0, e_div0[seen]);
               check_val($sformatf("alu_sel[%0d]", seen), alu_sel, e_sel[seen]);
               check_val($sformatf("alu_in[%0d]", seen), {alu_in_1, alu_in_2}, {e_a[seen], e_b[seen]});
               check_val($sformatf("alu_carry[%0d]", seen), alu_carry, e_cin[seen]);
               obs_data[seen] = res_data; obs_flags[seen] = res_flags; obs_sel[seen] = alu_sel;
               obs_carry[seen] = alu_carry; obs_div0[seen] = res_div0;
            end else begin
               check_val("extra_result", seen, n);
            end
            snap = {13'd0, res_data, res_flags, res_index, res_div0};
            seen++;
            if (mode == 2) stall = 5;
         end else if (res_valid) begin
            check_val("hold_stable", {13'd0, res_data, res_flags, res_index, res_div0}, snap);
         end
         if (done) begin
            got_done = 1; done_cyc = cyc;
            check_val("busy_at_done", busy, 0);
         end
         if (abort_at >= 0 && seen == abort_at + 1) begin
            in_rst = 1'b1;
            @(posedge in_clk); #1;
            in_rst = 1'b0;
            check_val("abort_busy", busy, 0);
            check_val("abort_valid", res_valid, 0);
            check_val("abort_wdt", alu_wdt_rst, 1);
            saw_done = 0;
            repeat (8) begin
               @(posedge in_clk); #1;
               if (done) saw_done = 1;
            end
            check_val("abort_no_done", saw_done, 0);
            return;
         end
         // A write attempted while busy must not reach the program memory.
         prog_wr_en = (n > 0 && cyc == 1);
         prog_wr_addr = '0; prog_wr_data = ~prog_m[0];
         prev_valid = res_valid;
         case (mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom_range(0, 1));
            default: begin
               if (stall > 0) begin res_ready = 1'b0; stall--; end
               else res_ready = 1'b1;
            end
         endcase
         prev_ready = res_ready;
         if (!got_done) begin
            @(posedge in_clk); #1;
            cyc++;
         end
      end
      prog_wr_en = 1'b0;
      check_val("done_seen", got_done, 1);
      check_val("result_count", seen, n);
      check_val("kick_count", kick_q.size(), exp_kicks);
      for (int k = 0; k < kick_q.size() && k < exp_kicks; k++)
         check_val($sformatf("kick_pos[%0d]", k), kick_q[k], k * KE);
      if (mode == 0) check_val("latency", done_cyc, exp_kicks + n * (SETTLE + 3));
      @(posedge in_clk); #1;
      check_val("done_pulse", done, 0);
      check_val("idle_busy", busy, 0);
   endtask

   initial begin
      in_rst = 1'b1; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
      prog_len = '0; start = 1'b0; res_ready = 1'b1;
      repeat (3) @(posedge in_clk);
      #1;
      check_val("rst_ctrl", {busy, done, res_valid, res_div0, alu_carry}, 0);
      check_val("rst_alu", {alu_sel, alu_in_1, alu_in_2}, 0);
      check_val("rst_res", {res_data, res_flags, res_index}, 0);
      check_val("rst_wdt", alu_wdt_rst, 1);
      in_rst = 1'b0;
      @(posedge in_clk); #1;
      check_val("post_rst_wdt", alu_wdt_rst, 0);

      // Signed overflow on ADD.
      write_prog(0, {1'b0, 5'd0, 8'h7F, 8'h01});
      run_prog(1, 0, -1);
      check_val("add_data", obs_data[0], 8'h80);
      check_val("add_ovf_sign", {obs_flags[0][2], obs_flags[0][4]}, 2'b11);

      // Carry chained into ADDC.
      write_prog(0, {1'b0, 5'd0, 8'hFF, 8'h01});
      write_prog(1, {1'b1, 5'd1, 8'h00, 8'h00});
      run_prog(2, 0, -1);
      check_val("chain_cin", obs_carry[1], 1);
      check_val("chain_data", obs_data[1], 8'h01);

      // Divide by zero.
      write_prog(0, {1'b0, 5'd4, 8'h10, 8'h00});
      run_prog(1, 0, -1);
      check_val("div0_sel", obs_sel[0], 5'd31);
      check_val("div0_data_flag", {obs_data[0], obs_div0[0]}, {8'h00, 1'b1});

      // Watchdog cadence and backpressure.
      rand_prog(10);
      run_prog(10, 2, -1);

      // Reset mid-run, then a clean rerun from index 0.
      rand_prog(6);
      run_prog(6, 0, 3);
      run_prog(6, 0, -1);

      // Empty program.
      run_prog(0, 0, -1);

      for (int it = 0; it < 6; it++) begin
         rand_prog(DEPTH);
         run_prog($urandom_range(0, 20), $urandom_range(0, 2), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, 16, program memory entries (power of 2).
REQ-002 Parameter SETTLE_CYCLES, 1, cycles between operand drive and result capture (1..15).
REQ-003 Parameter KICK_EVERY, 8, instructions issued between ALU watchdog resets (≥1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 in_clk  input  1  clock; all state on rising edge.
REQ-006 in_rst  input  1  synchronous active-high reset.
REQ-007 prog_wr_en  input  1  program write strobe.
REQ-008 prog_wr_addr  input  log2(DEPTH)  program write address.
REQ-009 prog_wr_data  input  22  {use_carry[21], alu_sel[20:16], op_a[15:8], op_b[7:0]}.
REQ-010 prog_len  input  log2(DEPTH)+1  instruction count, sampled at start.
REQ-011 start  input  1  single-cycle run request.
REQ-012 busy / done  output  1 each  run in progress / one-cycle run-complete pulse.
REQ-013 alu_sel  output  5; alu_in_1, alu_in_2  output  8 each, signed; alu_carry  output  1; alu_wdt_rst  output  1; all to the ALU.
REQ-014 alu_out  input  8 signed; alu_flags  input  6  {zero, sign, parity, overflow, carry, aux} from the ALU.
REQ-015 res_valid  output  1; res_ready  input  1; res_data  output  8; res_flags  output  6; res_index  output  log2(DEPTH); res_div0  output  1.

Function
REQ-016 States: IDLE, KICK, ISSUE, SETTLE, CAPTURE, HOLD, FINISH.
REQ-017 IDLE: prog_wr_en writes memory; start with prog_len>0 -> KICK, index=0; start with prog_len=0 -> FINISH; busy=0.
REQ-018 prog_wr_en and start ignored while busy=1; prog_len above DEPTH clamps to DEPTH.
REQ-019 KICK: alu_wdt_rst=1 exactly one cycle, issue counter cleared, -> ISSUE.
REQ-020 ISSUE: drive alu_sel/alu_in_1/alu_in_2 from entry[index]; alu_carry = use_carry ? last captured carry flag : 0; -> SETTLE.
REQ-021 Operands held stable from ISSUE through CAPTURE; SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-022 Divide-by-zero: alu_sel 00100 or 00101 with op_b=0 -> alu_sel driven 11111 (ALU default, result 0), res_div0=1, res_data=0.
REQ-023 CAPTURE: register alu_out, alu_flags, index into res_*; res_valid=1 next cycle; -> HOLD.
REQ-024 HOLD: res_* stable while res_valid=1 and res_ready=0; on res_ready=1 handshake completes, res_valid=0.
REQ-025 After handshake: last index -> FINISH; issue counter = KICK_EVERY -> KICK; else -> ISSUE, index+1.
REQ-026 Carry chain register updates only at CAPTURE; cleared at start and reset.
REQ-027 FINISH: done=1 one cycle, busy=0, -> IDLE; total latency per instruction without backpressure = SETTLE_CYCLES+3 cycles.
REQ-028 Outputs other than res_* are registered; alu_wdt_rst never asserted outside KICK or reset.

Reset
REQ-029 in_rst mid-run aborts immediately to IDLE, no done pulse, result discarded.
REQ-030 Reset values: busy, done, res_valid, res_div0, alu_carry =0; alu_sel, alu_in_1, alu_in_2, res_data, res_flags, res_index =0; alu_wdt_rst=1 during reset cycles; program memory not cleared.

Structure
REQ-031 Shared package holds state enum, opcode constants (ADD 00000 ... PASS2 10110, NOP 11111), flag bit positions, instruction field offsets.
REQ-032 One sub-module alu_prog_mem (DEPTH x 22, sync write, async read).

Verification
REQ-033 prog {ADD,0x7F,0x01}, len 1, res_ready=1 -> res_data 0x80, overflow=1, sign=1, done after SETTLE_CYCLES+4 cycles from start.
REQ-034 {ADD,0xFF,0x01} then {ADDC use_carry,0x00,0x00} -> second issue alu_carry equals first captured carry flag.
REQ-035 {DIV,0x10,0x00} -> alu_sel=11111, res_data 0x00, res_div0=1.
REQ-036 len 10, KICK_EVERY 8 -> alu_wdt_rst pulses before instr 0 and instr 8 only; res_ready held 0 for 5 cycles -> res_* stable, no skipped index.
REQ-037 in_rst at instr 3 of 6 -> busy=0 next cycle, no done; next start runs from index 0.
REQ-038 start with prog_len 0 -> done one cycle later, no alu_wdt_rst pulse, res_valid never asserted.
